pcie_tx_arb_q: RTL and testbench

PCIE_TX_ARB_Q -- requirements
Module: pcie_tx_arb_q

---
 rtl/pcie_tx_arb_q_if.sv | 32 +++
 rtl/pcie_tx_arb_q.sv | 178 +++++++++++++++++
 tb/tb_pcie_tx_arb_q.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_tx_arb_q_if.sv
// Bundle of request-side and dequeue-side signals for the PCIe TX arbiter queue.
// The master modport is the traffic source/sink, the slave modport is the queue.
interface pcie_tx_arb_q_if #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int NUM_PORTS = 4,
   parameter int PORT_BITS = 2
);
   localparam int CNT_BITS = $clog2(DEPTH + 1);

   logic [NUM_PORTS-1:0]       req_v;
   logic [NUM_PORTS*WIDTH-1:0] req_data;
   logic [NUM_PORTS-1:0]       req_last;
   logic [NUM_PORTS-1:0]       req_grant;
   logic                       deq_en;
   logic [WIDTH-1:0]           deq_data;
   logic [PORT_BITS-1:0]       deq_port;
   logic                       deq_last;
   logic                       empty;
   logic                       full;
   logic [CNT_BITS-1:0]        count;

   modport master (
      output req_v, req_data, req_last, deq_en,
      input  req_grant, deq_data, deq_port, deq_last, empty, full, count
   );

   modport slave (
      input  req_v, req_data, req_last, deq_en,
      output req_grant, deq_data, deq_port, deq_last, empty, full, count
   );
endinterface

// File: rtl/pcie_tx_arb_q.sv
// Round-robin TLP arbiter with per-TLP port lock feeding a FIFO whose head is an
// output register backed by DEPTH-1 RAM slots.
module pcie_tx_arb_q #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 32,
   parameter int NUM_PORTS = 4,
   parameter int PORT_BITS = 2
) (
   input logic            clk,
   input logic            rst,
   pcie_tx_arb_q_if.slave bus
);
   localparam int RAM_DEPTH = DEPTH - 1;
   localparam int AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int CW        = $clog2(DEPTH + 1);
   localparam int EW        = WIDTH + PORT_BITS + 1;

   typedef enum logic {
      ARB_OPEN,
      ARB_LOCKED
   } arb_state_t;

   arb_state_t           state_q, state_d;
   logic [PORT_BITS-1:0] rr_ptr_q, rr_ptr_d;
   logic [PORT_BITS-1:0] lock_port_q, lock_port_d;

   logic                 gnt_any;
   logic [PORT_BITS-1:0] gnt_idx;
   logic [NUM_PORTS-1:0] grant;
   logic [WIDTH-1:0]     gnt_data;
   logic                 gnt_last;
   int                   cand;
   logic [PORT_BITS-1:0] cand_idx;

   logic [EW-1:0]        ram [RAM_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q, count_d;
   logic                 empty_q, full_q;
   logic [WIDTH-1:0]     head_data_q;
   logic [PORT_BITS-1:0] head_port_q;
   logic                 head_last_q;

   logic                 push, pop, ram_empty, head_load, bypass, ram_rd, ram_wr;
   logic [EW-1:0]        ram_rd_entry;

   function automatic logic [PORT_BITS-1:0] next_port(input logic [PORT_BITS-1:0] p);
      if (int'(p) >= NUM_PORTS - 1) return '0;
      return p + PORT_BITS'(1);
   endfunction

   function automatic logic [AW-1:0] next_slot(input logic [AW-1:0] p);
      if (int'(p) >= RAM_DEPTH - 1) return '0;
      return p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ARB_OPEN;
         rr_ptr_q    <= '0;
         lock_port_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_port_q <= lock_port_d;
      end
   end

   // A non-last beat pins the arbiter to its port until that port sends last.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lock_port_d = lock_port_q;
      gnt_any     = 1'b0;
      gnt_idx     = '0;
      grant       = '0;
      cand        = 0;
      cand_idx    = '0;
      if (!rst && !full_q) begin
         if (state_q == ARB_LOCKED) begin
            if (bus.req_v[lock_port_q]) begin
               gnt_any = 1'b1;
               gnt_idx = lock_port_q;
            end
         end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               cand = int'(rr_ptr_q) + i;
               if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
               cand_idx = PORT_BITS'(cand);
               if (!gnt_any && bus.req_v[cand_idx]) begin
                  gnt_any = 1'b1;
                  gnt_idx = cand_idx;
               end
            end
         end
      end
      if (gnt_any) begin
         grant[gnt_idx] = 1'b1;
         if (bus.req_last[gnt_idx]) begin
            state_d  = ARB_OPEN;
            rr_ptr_d = next_port(gnt_idx);
         end else begin
            state_d     = ARB_LOCKED;
            lock_port_d = gnt_idx;
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      gnt_last = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt_idx == PORT_BITS'(i)) begin
            gnt_data = bus.req_data[i*WIDTH +: WIDTH];
            gnt_last = bus.req_last[i];
         end
      end
   end

   // The head register is refilled from RAM first; a fresh beat bypasses RAM only when RAM is empty.
   always_comb begin
      push         = gnt_any;
      pop          = bus.deq_en & ~empty_q;
      ram_empty    = (count_q < CW'(2));
      head_load    = empty_q | pop;
      bypass       = head_load & ram_empty & push;
      ram_rd       = head_load & ~ram_empty;
      ram_wr       = push & ~bypass;
      ram_rd_entry = ram[rd_ptr_q];
      count_d      = count_q;
      if (push && !pop) count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (ram_wr) ram[wr_ptr_q] <= {gnt_data, gnt_idx, gnt_last};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         head_data_q <= '0;
         head_port_q <= '0;
         head_last_q <= 1'b0;
      end else begin
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CW'(DEPTH));
         if (ram_wr) wr_ptr_q <= next_slot(wr_ptr_q);
         if (ram_rd) begin
            rd_ptr_q    <= next_slot(rd_ptr_q);
            head_data_q <= ram_rd_entry[EW-1 -: WIDTH];
            head_port_q <= ram_rd_entry[PORT_BITS:1];
            head_last_q <= ram_rd_entry[0];
         end else if (bypass) begin
            head_data_q <= gnt_data;
            head_port_q <= gnt_idx;
            head_last_q <= gnt_last;
         end
      end
   end

   assign bus.req_grant = grant;
   assign bus.deq_data  = head_data_q;
   assign bus.deq_port  = head_port_q;
   assign bus.deq_last  = head_last_q;
   assign bus.empty     = empty_q;
   assign bus.full      = full_q;
   assign bus.count     = count_q;

   // Grant must stay one-hot-or-zero, backed by a request, and silent at full.
   assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   assert property (@(posedge clk) disable iff (rst) (grant & ~bus.req_v) == '0);
   assert property (@(posedge clk) disable iff (rst) full_q |-> (grant == '0));
endmodule

// File: tb/tb_pcie_tx_arb_q.sv
// Directed bench for pcie_tx_arb_q: one task per scenario, inputs driven on the
// falling edge and outputs compared 1 time unit later.
module tb_pcie_tx_arb_q;
   localparam int WIDTH     = 32;
   localparam int DEPTH     = 32;
   localparam int NUM_PORTS = 4;
   localparam int PORT_BITS = 2;
   localparam int CW        = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pcie_tx_arb_q_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) bus ();

   pcie_tx_arb_q #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic drive_idle();
      bus.req_v    = '0;
      bus.req_last = '0;
      bus.req_data = '0;
      bus.deq_en   = 1'b0;
   endtask

   task automatic set_data(input int p, input logic [WIDTH-1:0] val);
      bus.req_data[p*WIDTH +: WIDTH] = val;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1'b1;
      bus.req_v = '1;
      bus.req_last = '1;
      @(negedge clk); #1;
      checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", bus.req_grant); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", bus.full); end
      checks++; if (bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
      checks++; if (bus.deq_data !== 32'h0 || bus.deq_port !== 2'd0 || bus.deq_last !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_head: got %h/%0d/%b expected 0/0/0", bus.deq_data, bus.deq_port, bus.deq_last); end
      rst = 1'b0;
      drive_idle();
   endtask

   task automatic test_fill_round_robin();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         bus.req_v = 4'hF;
         bus.req_last = 4'hF;
         for (int p = 0; p < NUM_PORTS; p++) set_data(p, 32'hA000_0000 + 32'(p));
         #1;
         checks++; if (bus.req_grant !== 4'(1 << (i % 4))) begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", i, bus.req_grant, 4'(1 << (i % 4))); end
         checks++; if (bus.count !== CW'(i)) begin errors++; $display("[TB] FAIL rr_count[%0d]: got %0d expected %0d", i, bus.count, i); end
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("[TB] FAIL full_grant[%0d]: got %b expected 0000", k, bus.req_grant); end
         checks++; if (bus.full !== 1'b1 || bus.count !== CW'(32)) begin errors++; $display("[TB] FAIL full_flag[%0d]: got full=%b count=%0d expected 1/32", k, bus.full, bus.count); end
      end
      checks++; if (bus.deq_port !== 2'd0 || bus.deq_data !== 32'hA000_0000 || bus.deq_last !== 1'b1 || bus.empty !== 1'b0) begin
         errors++; $display("[TB] FAIL full_head: got %0d/%h/%b empty=%b expected 0/a0000000/1 empty=0", bus.deq_port, bus.deq_data, bus.deq_last, bus.empty); end
   endtask

   task automatic test_full_pop();
      int exp_p;
      @(negedge clk);
      bus.deq_en = 1'b1;
      #1;
      checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("[TB] FAIL fullpop_nogrant: got %b expected 0000", bus.req_grant); end
      @(negedge clk);
      bus.deq_en = 1'b0;
      #1;
      checks++; if (bus.count !== CW'(31) || bus.full !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_count: got count=%0d full=%b expected 31/0", bus.count, bus.full); end
      checks++; if (bus.req_grant !== 4'b0001) begin errors++; $display("[TB] FAIL fullpop_regrant: got %b expected 0001", bus.req_grant); end
      checks++; if (bus.deq_port !== 2'd1) begin errors++; $display("[TB] FAIL fullpop_head: got %0d expected 1", bus.deq_port); end
      @(negedge clk);
      bus.req_v = '0;
      bus.deq_en = 1'b1;
      #1;
      checks++; if (bus.count !== CW'(32) || bus.full !== 1'b1) begin errors++; $display("[TB] FAIL refill_full: got count=%0d full=%b expected 32/1", bus.count, bus.full); end
      for (int k = 1; k < DEPTH; k++) begin
         @(negedge clk); #1;
         exp_p = (k < DEPTH - 1) ? (k + 1) % 4 : 0;
         checks++; if (bus.deq_port !== 2'(exp_p) || bus.empty !== 1'b0) begin errors++; $display("[TB] FAIL drain_port[%0d]: got %0d empty=%b expected %0d empty=0", k, bus.deq_port, bus.empty, exp_p); end
      end
      @(negedge clk);
      bus.deq_en = 1'b0;
      #1;
      checks++; if (bus.empty !== 1'b1 || bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL drain_empty: got empty=%b count=%0d expected 1/0", bus.empty, bus.count); end
   endtask

   task automatic test_lock();
      logic [3:0] vin [4]  = '{4'b0110, 4'b0110, 4'b0110, 4'b0100};
      logic [3:0] lin [4]  = '{4'b0100, 4'b0100, 4'b0110, 4'b0110};
      logic [3:0] gexp [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
      int pexp [4]         = '{1, 1, 1, 2};
      logic lexp [4]       = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] dexp [4] = '{32'h11, 32'h12, 32'h13, 32'h21};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.req_v = vin[c];
         bus.req_last = lin[c];
         set_data(1, 32'h11 + 32'(c));
         set_data(2, 32'h21);
         #1;
         checks++; if (bus.req_grant !== gexp[c]) begin errors++; $display("[TB] FAIL lock_grant[%0d]: got %b expected %b", c, bus.req_grant, gexp[c]); end
      end
      @(negedge clk);
      drive_idle();
      bus.deq_en = 1'b1;
      #1;
      checks++; if (bus.count !== CW'(4)) begin errors++; $display("[TB] FAIL lock_count: got %0d expected 4", bus.count); end
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         checks++; if (bus.deq_port !== 2'(pexp[c]) || bus.deq_last !== lexp[c] || bus.deq_data !== dexp[c]) begin
            errors++; $display("[TB] FAIL lock_deq[%0d]: got %0d/%b/%h expected %0d/%b/%h", c, bus.deq_port, bus.deq_last, bus.deq_data, pexp[c], lexp[c], dexp[c]); end
      end
      @(negedge clk);
      bus.deq_en = 1'b0;
      #1;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL lock_empty: got %b expected 1", bus.empty); end
   endtask

   task automatic test_bubble();
      logic [3:0] vin [5]  = '{4'b0010, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
      logic [3:0] lin [5]  = '{4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
      logic [3:0] gexp [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
      int pexp [3]         = '{1, 1, 0};
      logic [31:0] dexp [3] = '{32'h31, 32'h32, 32'h40};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.req_v = vin[c];
         bus.req_last = lin[c];
         set_data(1, (c == 0) ? 32'h31 : 32'h32);
         set_data(0, 32'h40);
         #1;
         checks++; if (bus.req_grant !== gexp[c]) begin errors++; $display("[TB] FAIL bubble_grant[%0d]: got %b expected %b", c, bus.req_grant, gexp[c]); end
      end
      @(negedge clk);
      drive_idle();
      bus.deq_en = 1'b1;
      #1;
      checks++; if (bus.count !== CW'(3)) begin errors++; $display("[TB] FAIL bubble_count: got %0d expected 3", bus.count); end
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         checks++; if (bus.deq_port !== 2'(pexp[c]) || bus.deq_data !== dexp[c]) begin
            errors++; $display("[TB] FAIL bubble_deq[%0d]: got %0d/%h expected %0d/%h", c, bus.deq_port, bus.deq_data, pexp[c], dexp[c]); end
      end
      @(negedge clk);
      bus.deq_en = 1'b0;
   endtask

   task automatic test_latency_and_empty_pop();
      @(negedge clk);
      bus.req_v = 4'b0001;
      bus.req_last = 4'b0001;
      set_data(0, 32'h55);
      bus.deq_en = 1'b1;
      #1;
      checks++; if (bus.empty !== 1'b1 || bus.req_grant !== 4'b0001) begin errors++; $display("[TB] FAIL lat_n: got empty=%b grant=%b expected 1/0001", bus.empty, bus.req_grant); end
      @(negedge clk);
      bus.req_v = '0;
      #1;
      checks++; if (bus.empty !== 1'b0 || bus.count !== CW'(1) || bus.deq_data !== 32'h55 || bus.deq_port !== 2'd0) begin
         errors++; $display("[TB] FAIL lat_n1: got empty=%b count=%0d data=%h port=%0d expected 0/1/55/0", bus.empty, bus.count, bus.deq_data, bus.deq_port); end
      @(negedge clk); #1;
      checks++; if (bus.empty !== 1'b1 || bus.count !== CW'(0)) begin errors++; $display("[TB] FAIL lat_n2: got empty=%b count=%0d expected 1/0", bus.empty, bus.count); end
      @(negedge clk); #1;
      checks++; if (bus.empty !== 1'b1 || bus.count !== CW'(0) || bus.deq_data !== 32'h55 || bus.deq_last !== 1'b1) begin
         errors++; $display("[TB] FAIL empty_pop: got empty=%b count=%0d data=%h last=%b expected 1/0/55/1", bus.empty, bus.count, bus.deq_data, bus.deq_last); end
      bus.deq_en = 1'b0;
   endtask

   task automatic test_reset_mid_tlp();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.req_v = (c < 4) ? 4'b0001 : 4'b1000;
         bus.req_last = (c < 4) ? 4'b0001 : 4'b0000;
         set_data(0, 32'h60 + 32'(c));
         set_data(3, 32'h70);
         #1;
         checks++; if (bus.req_grant !== bus.req_v) begin errors++; $display("[TB] FAIL rstmid_fill[%0d]: got %b expected %b", c, bus.req_grant, (c < 4) ? 4'b0001 : 4'b1000); end
      end
      @(negedge clk);
      rst = 1'b1;
      bus.req_v = 4'b1001;
      bus.req_last = 4'b0000;
      #1;
      checks++; if (bus.count !== CW'(5)) begin errors++; $display("[TB] FAIL rstmid_count: got %0d expected 5", bus.count); end
      checks++; if (bus.req_grant !== 4'b0000) begin errors++; $display("[TB] FAIL rstmid_grant: got %b expected 0000", bus.req_grant); end
      @(negedge clk); #1;
      checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== CW'(0) || bus.deq_data !== 32'h0 || bus.deq_port !== 2'd0 || bus.deq_last !== 1'b0) begin
         errors++; $display("[TB] FAIL rstmid_state: got e=%b f=%b c=%0d d=%h p=%0d l=%b expected 1/0/0/0/0/0", bus.empty, bus.full, bus.count, bus.deq_data, bus.deq_port, bus.deq_last); end
      rst = 1'b0;
      bus.req_v = 4'b0001;
      bus.req_last = 4'b0001;
      set_data(0, 32'h80);
      #1;
      checks++; if (bus.req_grant !== 4'b0001) begin errors++; $display("[TB] FAIL rstmid_unlock: got %b expected 0001", bus.req_grant); end
      @(negedge clk);
      drive_idle();
      #1;
      checks++; if (bus.count !== CW'(1) || bus.empty !== 1'b0 || bus.deq_port !== 2'd0 || bus.deq_data !== 32'h80) begin
         errors++; $display("[TB] FAIL rstmid_after: got c=%0d e=%b p=%0d d=%h expected 1/0/0/80", bus.count, bus.empty, bus.deq_port, bus.deq_data); end
   endtask

   initial begin
      test_reset();
      test_fill_round_robin();
      test_full_pop();
      test_lock();
      test_bubble();
      test_latency_and_empty_pop();
      test_reset_mid_tlp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
